// File: rtl/issue_stage.sv
// Fetch/issue front end: sequential imem requests, issue register with a one-entry skid buffer.
// Optional stall cycle counter is enabled by defining ISSUE_STALL_COUNT_EN.
module issue_stage #(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = {PC_WIDTH{1'b0}},
  parameter int                  PC_STEP  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_rvalid,
  input  logic [31:0]         imem_rdata,
  output logic [31:0]         issue_reg_output,
  output logic [PC_WIDTH-1:0] issue_pc,
  output logic [31:0]         decode_instr
`ifdef ISSUE_STALL_COUNT_EN
  ,
  output logic [31:0]         stall_count
`endif
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] resp_pc_q, resp_pc_d;
  logic [31:0]         issue_q, issue_d;
  logic [PC_WIDTH-1:0] issue_pc_q, issue_pc_d;
  logic [31:0]         skid_q, skid_d;
  logic [PC_WIDTH-1:0] skid_pc_q, skid_pc_d;
  logic                skid_valid_q, skid_valid_d;
  logic                run_s;
  logic                req_s;
  logic                resp_s;

  assign run_s  = (state_q == ST_RUN);
  assign req_s  = run_s && !stall && !redirect_valid;
  assign resp_s = run_s && imem_rvalid;

  assign imem_req         = req_s;
  assign imem_addr        = pc_q;
  assign issue_reg_output = issue_q;
  assign issue_pc         = issue_pc_q;
  assign decode_instr     = stall ? 32'h0000_0000 : issue_q;

  // Next-state: FSM sequencing, PC advance, issue register and skid buffer updates.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    resp_pc_d    = resp_pc_q;
    issue_d      = issue_q;
    issue_pc_d   = issue_pc_q;
    skid_d       = skid_q;
    skid_pc_d    = skid_pc_q;
    skid_valid_d = skid_valid_q;

    case (state_q)
      ST_BOOT:  state_d = ST_RUN;
      ST_RUN:   state_d = ST_RUN;
      ST_FLUSH: state_d = ST_RUN;
      default:  state_d = ST_BOOT;
    endcase

    if (req_s) begin
      pc_d      = pc_q + PC_WIDTH'(PC_STEP);
      resp_pc_d = pc_q;
    end else begin
      pc_d      = pc_q;
      resp_pc_d = resp_pc_q;
    end

    // Redirect overrides everything, including a simultaneous stall or response.
    if (redirect_valid) begin
      state_d      = ST_FLUSH;
      pc_d         = redirect_pc;
      issue_d      = 32'h0000_0000;
      skid_valid_d = 1'b0;
    end else if (stall) begin
      if (resp_s) begin
        skid_d       = imem_rdata;
        skid_pc_d    = resp_pc_q;
        skid_valid_d = 1'b1;
      end else begin
        skid_valid_d = skid_valid_q;
      end
    end else if (resp_s) begin
      issue_d    = imem_rdata;
      issue_pc_d = resp_pc_q;
    end else if (skid_valid_q) begin
      issue_d      = skid_q;
      issue_pc_d   = skid_pc_q;
      skid_valid_d = 1'b0;
    end else begin
      issue_d = 32'h0000_0000;
    end
  end

  // Pipeline state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_PC;
      resp_pc_q    <= {PC_WIDTH{1'b0}};
      issue_q      <= 32'h0000_0000;
      issue_pc_q   <= {PC_WIDTH{1'b0}};
      skid_q       <= 32'h0000_0000;
      skid_pc_q    <= {PC_WIDTH{1'b0}};
      skid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      resp_pc_q    <= resp_pc_d;
      issue_q      <= issue_d;
      issue_pc_q   <= issue_pc_d;
      skid_q       <= skid_d;
      skid_pc_q    <= skid_pc_d;
      skid_valid_q <= skid_valid_d;
    end
  end

`ifdef ISSUE_STALL_COUNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of stalled RUN cycles; redirects do not clear it.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && run_s && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= 32'h0000_0000;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
`endif

endmodule
